east_port_arbiter: RTL and testbench

Round-robin arbiter and output register for the router's east output link. Up to four input-side forwarders (local, west, north, south) present packets already steered east by their routing logic; this block picks one per cycle, decrements the packet's X-hop field, and holds it on the east link under a valid/ready handshake until the downstream router accepts it. It sits between the per-input `forward_east` routing stages and the east link register.

---
 rtl/east_port_arbiter.sv | 114 +++++++++++
 tb/tb_east_port_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/east_port_arbiter.sv
// rtl/east_port_arbiter.sv - round-robin arbiter and output register for the east link
module east_port_arbiter #(
   parameter int WIDTH  = 16,
   parameter int DX_LSB = 4,
   parameter int DX_W   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] packet_local,
   input  logic [WIDTH-1:0] packet_west,
   input  logic [WIDTH-1:0] packet_north,
   input  logic [WIDTH-1:0] packet_south,
   input  logic             valid_local,
   input  logic             valid_west,
   input  logic             valid_north,
   input  logic             valid_south,
   output logic             ready_local,
   output logic             ready_west,
   output logic             ready_north,
   output logic             ready_south,
   output logic [WIDTH-1:0] packet_east,
   output logic             valid_east,
   input  logic             ready_east,
   output logic [15:0]      pkt_count,
   output logic [1:0]       grant_idx
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t           state, state_next;
   logic [1:0]       rr_ptr;
   logic [3:0]       valid_vec;
   logic [WIDTH-1:0] pkt_in [4];
   logic             slot_free;
   logic             grant_any;
   logic [1:0]       grant_sel;
   logic [1:0]       scan_idx;
   logic [3:0]       ready_vec;
   logic [WIDTH-1:0] sel_pkt;
   logic [WIDTH-1:0] cap_pkt;
   logic [DX_W-1:0]  dx_in;

   assign valid_vec = {valid_south, valid_north, valid_west, valid_local};
   assign pkt_in[0] = packet_local;
   assign pkt_in[1] = packet_west;
   assign pkt_in[2] = packet_north;
   assign pkt_in[3] = packet_south;

   assign valid_east = (state == FULL);
   assign slot_free  = !valid_east || ready_east;

   // First valid requester at or after rr_ptr, wrapping modulo 4.
   always_comb begin
      grant_any = 1'b0;
      grant_sel = 2'd0;
      scan_idx  = 2'd0;
      for (int i = 0; i < 4; i++) begin
         scan_idx = rr_ptr + 2'(i);
         if (slot_free && !grant_any && valid_vec[scan_idx]) begin
            grant_any = 1'b1;
            grant_sel = scan_idx;
         end
      end
   end

   // Readies are forced low while reset is held, since the emptied register frees the slot.
   always_comb begin
      ready_vec = 4'b0000;
      if (grant_any && rst_n)
         ready_vec[grant_sel] = 1'b1;
   end

   assign ready_local = ready_vec[0];
   assign ready_west  = ready_vec[1];
   assign ready_north = ready_vec[2];
   assign ready_south = ready_vec[3];

   // Saturating decrement of the dx field; every other bit passes through.
   always_comb begin
      sel_pkt = pkt_in[grant_sel];
      dx_in   = sel_pkt[DX_LSB +: DX_W];
      cap_pkt = sel_pkt;
      if (dx_in != '0)
         cap_pkt[DX_LSB +: DX_W] = dx_in - 1'b1;
   end

   always_comb begin
      state_next = state;
      if (grant_any)
         state_next = FULL;
      else if (valid_east && ready_east)
         state_next = EMPTY;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= EMPTY;
         packet_east <= '0;
         grant_idx   <= 2'd0;
         rr_ptr      <= 2'd0;
         pkt_count   <= 16'd0;
      end else begin
         state <= state_next;
         if (grant_any) begin
            packet_east <= cap_pkt;
            grant_idx   <= grant_sel;
            rr_ptr      <= grant_sel + 2'd1;
         end
         if (valid_east && ready_east)
            pkt_count <= pkt_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_east_port_arbiter.sv
// tb/tb_east_port_arbiter.sv - directed self-checking bench for east_port_arbiter
module tb_east_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] packet_local = '0, packet_west = '0, packet_north = '0, packet_south = '0;
   logic        valid_local = 1'b0, valid_west = 1'b0, valid_north = 1'b0, valid_south = 1'b0;
   logic        ready_local, ready_west, ready_north, ready_south;
   logic [15:0] packet_east;
   logic        valid_east;
   logic        ready_east = 1'b0;
   logic [15:0] pkt_count;
   logic [1:0]  grant_idx;
   logic [3:0]  rdy;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   east_port_arbiter #(.WIDTH(16), .DX_LSB(4), .DX_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .packet_local(packet_local), .packet_west(packet_west),
      .packet_north(packet_north), .packet_south(packet_south),
      .valid_local(valid_local), .valid_west(valid_west),
      .valid_north(valid_north), .valid_south(valid_south),
      .ready_local(ready_local), .ready_west(ready_west),
      .ready_north(ready_north), .ready_south(ready_south),
      .packet_east(packet_east), .valid_east(valid_east), .ready_east(ready_east),
      .pkt_count(pkt_count), .grant_idx(grant_idx)
   );

   assign rdy = {ready_south, ready_north, ready_west, ready_local};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic set_valid(input logic [3:0] v);
      {valid_south, valid_north, valid_west, valid_local} = v;
      #1;
   endtask

   task automatic do_reset;
      set_valid(4'b0000);
      ready_east = 1'b0;
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      #1;
   endtask

   logic [15:0] fair_exp [4];

   initial begin
      fair_exp[0] = 16'h1120;
      fair_exp[1] = 16'h2230;
      fair_exp[2] = 16'h3340;
      fair_exp[3] = 16'h4450;

      // Reset asserted mid-stall clears everything without a clock edge
      do_reset();
      packet_local = 16'h0050;
      set_valid(4'b0001);
      check("t1_ready_empty", rdy, 4'b0001);
      step();
      check("t1_full", valid_east, 1'b1);
      check("t1_stall_ready", rdy, 4'b0000);
      rst_n = 1'b0;
      #1;
      check("t1_rst_valid", valid_east, 1'b0);
      check("t1_rst_count", pkt_count, 16'd0);
      check("t1_rst_ready", rdy, 4'b0000);
      check("t1_rst_packet", packet_east, 16'h0000);
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      // Round-robin with all four valid
      packet_local = 16'h1130;
      packet_west  = 16'h2240;
      packet_north = 16'h3350;
      packet_south = 16'h4460;
      ready_east = 1'b1;
      set_valid(4'b1111);
      for (int k = 0; k < 8; k++) begin
         check($sformatf("rr_ready_%0d", k), rdy, 4'b0001 << (k % 4));
         step();
         check($sformatf("rr_grant_%0d", k), grant_idx, k % 4);
         check($sformatf("rr_packet_%0d", k), packet_east, fair_exp[k % 4]);
         check($sformatf("rr_count_%0d", k), pkt_count, k);
      end
      set_valid(4'b0000);
      step();
      check("rr_count_final", pkt_count, 16'd8);
      check("rr_drained", valid_east, 1'b0);

      // Single west pass-through with dx decrement
      do_reset();
      ready_east = 1'b1;
      packet_west = 16'h0020;
      set_valid(4'b0010);
      check("t2_ready", rdy, 4'b0010);
      step();
      set_valid(4'b0000);
      check("t2_packet", packet_east, 16'h0010);
      check("t2_valid", valid_east, 1'b1);
      check("t2_grant", grant_idx, 2'd1);
      check("t2_count0", pkt_count, 16'd0);
      step();
      check("t2_count1", pkt_count, 16'd1);
      check("t2_empty", valid_east, 1'b0);

      // dx already zero saturates
      packet_local = 16'hA30F;
      set_valid(4'b0001);
      check("t3_ready", rdy, 4'b0001);
      step();
      set_valid(4'b0000);
      check("t3_packet", packet_east, 16'hA30F);
      check("t3_grant", grant_idx, 2'd0);
      step();
      check("t3_count", pkt_count, 16'd2);

      // rr_ptr now 1; lone south request is taken at once, pointer wraps to 0
      set_valid(4'b1000);
      check("t6_ready", rdy, 4'b1000);
      step();
      set_valid(4'b0000);
      check("t6_grant", grant_idx, 2'd3);
      check("t6_packet", packet_east, 16'h4450);
      step();
      check("t6_count", pkt_count, 16'd3);

      // Backpressure: local captured, then stall with north and south waiting
      packet_local = 16'h5570;
      packet_north = 16'h66A5;
      packet_south = 16'h77F1;
      set_valid(4'b0101);
      check("t6_rr_wrap", rdy, 4'b0001);
      step();
      check("t5_first", packet_east, 16'h5560);
      ready_east = 1'b0;
      set_valid(4'b1100);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("t5_stall_ready_%0d", k), rdy, 4'b0000);
         step();
         check($sformatf("t5_stall_packet_%0d", k), packet_east, 16'h5560);
         check($sformatf("t5_stall_valid_%0d", k), valid_east, 1'b1);
         check($sformatf("t5_stall_count_%0d", k), pkt_count, 16'd3);
      end
      ready_east = 1'b1;
      #1;
      check("t5_release_ready", rdy, 4'b0100);
      step();
      check("t5_north_packet", packet_east, 16'h6695);
      check("t5_north_grant", grant_idx, 2'd2);
      check("t5_count4", pkt_count, 16'd4);
      check("t5_south_ready", rdy, 4'b1000);
      step();
      set_valid(4'b0000);
      check("t5_south_packet", packet_east, 16'h77E1);
      check("t5_south_grant", grant_idx, 2'd3);
      check("t5_count5", pkt_count, 16'd5);
      step();
      check("t5_count6", pkt_count, 16'd6);
      check("t5_empty", valid_east, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
